// File: rtl/pal_pkg.sv
// Shared types and config-bit offset helpers for the sequential PAL fabric.
// Dimension arguments default to the fabric's default sizing.
package pal_pkg;

   localparam int DEF_N = 8;
   localparam int DEF_M = 6;
   localparam int DEF_P = 15;

   typedef struct packed {
      logic inv;
      logic reg_mode;
   } mc_cfg_t;

   function automatic int cfg_len(input int n, input int m, input int p);
      return p*2*(n+m) + m*p + 2*m;
   endfunction

   function automatic int and_idx(input int p, input int l, input int c,
                                  input int n = DEF_N, input int m = DEF_M);
      return p*2*(n+m) + 2*l + c;
   endfunction

   function automatic int or_idx(input int mo, input int p,
                                 input int n = DEF_N, input int m = DEF_M,
                                 input int np = DEF_P);
      return np*2*(n+m) + mo*np + p;
   endfunction

   function automatic int inv_idx(input int mo,
                                  input int n = DEF_N, input int m = DEF_M,
                                  input int np = DEF_P);
      return np*2*(n+m) + m*np + 2*mo;
   endfunction

   function automatic int reg_idx(input int mo,
                                  input int n = DEF_N, input int m = DEF_M,
                                  input int np = DEF_P);
      return np*2*(n+m) + m*np + 2*mo + 1;
   endfunction

endpackage

// File: rtl/pal_macrocell.sv
// One output macrocell: feedback flop, combinational/registered select,
// polarity inversion and gating while no configuration is active.
module pal_macrocell
   import pal_pkg::*;
(
   input  logic    clk,
   input  logic    res_n,
   input  logic    i_clr,
   input  logic    i_valid,
   input  logic    i_sum,
   input  mc_cfg_t i_cfg,
   output logic    o_q,
   output logic    o_out
);

   logic r_q;

   // The flop tracks the sum in both modes so feedback is always available.
   always_ff @(posedge clk) begin
      if (!res_n) begin
         r_q <= 1'b0;
      end else if (i_clr || !i_valid) begin
         r_q <= 1'b0;
      end else begin
         r_q <= i_sum;
      end
   end

   assign o_q   = r_q;
   assign o_out = i_valid & ((i_cfg.reg_mode ? r_q : i_sum) ^ i_cfg.inv);

endmodule

// File: rtl/pal_seq_core.sv
// PAL fabric with registered feedback and a serially loaded shadow config
// that is committed atomically when exactly CFG_LEN bits were shifted.
module pal_seq_core
   import pal_pkg::*;
#(
   parameter int N = 8,
   parameter int M = 6,
   parameter int P = 15
) (
   input  logic         clk,
   input  logic         res_n,
   input  logic         en,
   input  logic         cfg,
   output logic         cfg_out,
   input  logic [N-1:0] in_vars,
   output logic [M-1:0] out_vals,
   output logic         cfg_valid,
   output logic         cfg_err
);

   localparam int CFG_LEN = cfg_len(N, M, P);
   localparam int CW      = $clog2(CFG_LEN + 2);
   localparam int L       = N + M;
   localparam logic [CW-1:0] CNT_FULL = CW'(CFG_LEN);
   localparam logic [CW-1:0] CNT_SAT  = CW'(CFG_LEN + 1);

   logic [CFG_LEN-1:0] r_shadow;
   logic [CFG_LEN-1:0] r_active;
   logic [CW-1:0]      r_cnt;
   logic               r_en_d;
   logic               r_valid;
   logic               r_err;

   logic               w_rise;
   logic               w_fall;
   logic               w_commit_ok;
   logic [M-1:0]       w_q;
   logic [L-1:0]       w_lit;
   logic [P-1:0]       w_term;
   logic [M-1:0]       w_sum;

   assign w_rise      = en & ~r_en_d;
   assign w_fall      = ~en & r_en_d;
   assign w_commit_ok = w_fall && (r_cnt == CNT_FULL);

   always_ff @(posedge clk) begin
      if (!res_n) begin
         r_shadow <= '0;
         r_active <= '0;
         r_cnt    <= '0;
         r_en_d   <= 1'b0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_en_d <= en;
         if (en) begin
            r_shadow <= {cfg, r_shadow[CFG_LEN-1:1]};
            // The bit shifted on the rising edge of en is already the first one.
            if (w_rise) begin
               r_cnt <= CW'(1);
            end else if (r_cnt != CNT_SAT) begin
               r_cnt <= r_cnt + CW'(1);
            end
         end
         if (w_fall) begin
            if (r_cnt == CNT_FULL) begin
               r_active <= r_shadow;
               r_valid  <= 1'b1;
               r_err    <= 1'b0;
            end else begin
               r_err <= 1'b1;
            end
         end
      end
   end

   assign w_lit = {w_q, in_vars};

   for (genvar p = 0; p < P; p++) begin : g_term
      logic [L-1:0] w_en_t;
      logic [L-1:0] w_en_c;
      for (genvar l = 0; l < L; l++) begin : g_lit
         assign w_en_t[l] = r_active[and_idx(p, l, 0, N, M)];
         assign w_en_c[l] = r_active[and_idx(p, l, 1, N, M)];
      end
      // An empty term is 0; true and complement of one literal also give 0.
      assign w_term[p] = (|(w_en_t | w_en_c)) & ~(|(w_en_t & ~w_lit))
                         & ~(|(w_en_c & w_lit));
   end

   for (genvar gm = 0; gm < M; gm++) begin : g_out
      logic [P-1:0] w_sel;
      mc_cfg_t      w_mc;
      for (genvar p = 0; p < P; p++) begin : g_sel
         assign w_sel[p] = r_active[or_idx(gm, p, N, M, P)];
      end
      assign w_sum[gm]     = |(w_sel & w_term);
      assign w_mc.inv      = r_active[inv_idx(gm, N, M, P)];
      assign w_mc.reg_mode = r_active[reg_idx(gm, N, M, P)];

      pal_macrocell u_mc (
         .clk     (clk),
         .res_n   (res_n),
         .i_clr   (w_commit_ok),
         .i_valid (r_valid),
         .i_sum   (w_sum[gm]),
         .i_cfg   (w_mc),
         .o_q     (w_q[gm]),
         .o_out   (out_vals[gm])
      );
   end

   assign cfg_out   = r_shadow[0];
   assign cfg_valid = r_valid;
   assign cfg_err   = r_err;

endmodule

// File: tb/tb_pal_seq_core.sv
// Directed bench for pal_seq_core at N=4, M=2, P=4 (CFG_LEN=60).
// Config A: out0 = in0&in1 combinational, out1 = registered ~q1 (toggler).
module tb_pal_seq_core;
   import pal_pkg::*;

   localparam int N       = 4;
   localparam int M       = 2;
   localparam int P       = 4;
   localparam int CFG_LEN = cfg_len(N, M, P);
   localparam int W       = 5;

   // ---------------- clock / reset ----------------
   logic         clk = 1'b0;
   logic         res_n = 1'b0;
   logic         en = 1'b0;
   logic         cfg = 1'b0;
   logic [N-1:0] in_vars = '0;
   logic         cfg_out;
   logic [M-1:0] out_vals;
   logic         cfg_valid;
   logic         cfg_err;

   always #5 clk = ~clk;

   pal_seq_core #(.N(N), .M(M), .P(P)) dut (
      .clk       (clk),
      .res_n     (res_n),
      .en        (en),
      .cfg       (cfg),
      .cfg_out   (cfg_out),
      .in_vars   (in_vars),
      .out_vals  (out_vals),
      .cfg_valid (cfg_valid),
      .cfg_err   (cfg_err)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mask_q[$];
   string        name_q[$];
   int           n_checks = 0;
   int           n_errors = 0;

   logic [W-1:0] obs;
   assign obs = {cfg_out, cfg_err, cfg_valid, out_vals};

   // Reference state: config validity, error flag and the toggling q1.
   logic m_valid = 1'b0;
   logic m_err   = 1'b0;
   logic m_q1    = 1'b0;

   logic [127:0] cfg_a;
   logic [127:0] pat;
   logic [3:0]   in_pats [4];

   always @(negedge clk) begin : monitor
      logic [W-1:0] e;
      logic [W-1:0] mk;
      string        nm;
      while (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         mk = mask_q.pop_front();
         nm = name_q.pop_front();
         n_checks++;
         if ((obs & mk) !== (e & mk)) begin
            n_errors++;
            $display("FAIL %s: got {cfg_out,err,valid,out}=%b expected %b (mask %b) at %0t",
                     nm, obs & mk, e & mk, mk, $time);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_exp(input string nm, input logic [W-1:0] e, input logic [W-1:0] mk);
      exp_q.push_back(e);
      mask_q.push_back(mk);
      name_q.push_back(nm);
   endtask

   task automatic check_fabric(input string nm);
      logic [W-1:0] e;
      e = {1'b0, m_err, m_valid, m_valid & m_q1, m_valid & in_vars[0] & in_vars[1]};
      push_exp(nm, e, 5'b01111);
   endtask

   task automatic tick();
      @(posedge clk);
      if (!res_n) begin
         m_valid = 1'b0;
         m_err   = 1'b0;
         m_q1    = 1'b0;
      end else if (m_valid) begin
         m_q1 = ~m_q1;
      end
      #1;
   endtask

   task automatic shift_load(input logic [127:0] bits, input int n, input string nm);
      for (int i = 0; i < n; i++) begin
         en      = 1'b1;
         cfg     = bits[i];
         in_vars = 4'(i);
         if (i % 16 == 5) check_fabric({nm, "_during"});
         tick();
      end
      en  = 1'b0;
      cfg = 1'b0;
      tick();
      if (n == CFG_LEN) begin
         m_valid = 1'b1;
         m_err   = 1'b0;
         m_q1    = 1'b0;
      end else begin
         m_err = 1'b1;
      end
   endtask

   task automatic run_fabric(input int k, input string nm);
      for (int i = 0; i < k; i++) begin
         in_vars = in_pats[i % 4];
         check_fabric(nm);
         tick();
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      in_pats[0] = 4'b0011;
      in_pats[1] = 4'b0001;
      in_pats[2] = 4'b1111;
      in_pats[3] = 4'b0110;

      cfg_a = '0;
      cfg_a[and_idx(0, 0, 0, N, M)]     = 1'b1;
      cfg_a[and_idx(0, 1, 0, N, M)]     = 1'b1;
      cfg_a[and_idx(1, N + 1, 1, N, M)] = 1'b1;
      cfg_a[or_idx(0, 0, N, M, P)]      = 1'b1;
      cfg_a[or_idx(1, 1, N, M, P)]      = 1'b1;
      cfg_a[reg_idx(1, N, M, P)]        = 1'b1;

      pat = 128'h0A5C3F019B6E2D47;

      res_n = 1'b0;
      tick();
      tick();
      res_n = 1'b1;
      push_exp("reset_state", 5'b00000, 5'b11111);
      tick();

      shift_load(cfg_a, CFG_LEN, "load_a");
      run_fabric(4, "after_commit");

      shift_load(cfg_a, CFG_LEN - 1, "short_load");
      run_fabric(4, "short_hold");

      shift_load(cfg_a, CFG_LEN + 1, "long_load");
      run_fabric(3, "long_hold");

      shift_load(cfg_a, CFG_LEN, "reload");
      run_fabric(3, "reload_run");

      for (int i = 0; i < 2 * CFG_LEN; i++) begin
         en      = 1'b1;
         cfg     = (i < CFG_LEN) ? pat[i] : 1'b0;
         in_vars = in_pats[i % 4];
         if (i >= CFG_LEN) push_exp("readback", {pat[i - CFG_LEN], 4'b0000}, 5'b10000);
         if (i % 8 == 3) check_fabric("readback_fabric");
         tick();
      end
      en = 1'b0;
      tick();
      m_err = 1'b1;
      run_fabric(2, "post_readback");

      for (int i = 0; i < 30; i++) begin
         en  = 1'b1;
         cfg = pat[i];
         tick();
      end
      res_n = 1'b0;
      tick();
      res_n   = 1'b1;
      en      = 1'b0;
      in_vars = 4'b0011;
      push_exp("mid_reset", 5'b00000, 5'b11111);
      tick();
      push_exp("no_commit_after_reset", 5'b00000, 5'b11111);
      tick();
      run_fabric(2, "idle_after_reset");

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: %0d expected entries left unchecked", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
